// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch unit
package fetch_pkg;

    localparam logic [31:0] START_ADDRESS_DEFAULT = 32'h8002_0000;
    localparam int          MEM_LATENCY_DEFAULT   = 2;
    localparam int          FIFO_DEPTH_DEFAULT    = 4;

    typedef enum logic [1:0] {
        ACC_1W  = 2'b00,
        ACC_4W  = 2'b01,
        ACC_8W  = 2'b10,
        ACC_16W = 2'b11
    } acc_size_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
    } fetch_tag_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous instruction buffer with flush and occupancy count
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty;
    assign rd_data = store[rd_ptr];

    // A flush coinciding with a read still retires the head; the buffer just ends empty.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clock) begin
        if (do_wr) store[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - sequential instruction fetch with latency-tracked requests and redirect flush
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] START_ADDRESS = START_ADDRESS_DEFAULT,
    parameter int          MEM_LATENCY   = MEM_LATENCY_DEFAULT,
    parameter int          FIFO_DEPTH    = FIFO_DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_data_out,
    output logic [1:0]  mem_acc_size,
    output logic        mem_wren,
    output logic        mem_enable,
    input  logic        mem_busy,
    output logic [31:0] insn,
    output logic [31:0] insn_pc,
    output logic        insn_valid,
    input  logic        insn_ready
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0] pc;
    fetch_tag_t  tags [MEM_LATENCY];
    logic [CW-1:0] count;
    logic [CW-1:0] inflight;
    logic        issue;
    logic        fifo_empty;
    logic [63:0] head;

    assign mem_addr     = pc;
    assign mem_acc_size = ACC_1W;
    assign mem_wren     = 1'b0;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < MEM_LATENCY; i++) begin
            inflight = inflight + CW'(tags[i].valid);
        end
    end

    // Credit check counts every outstanding tag, so a returning word always has a slot.
    assign mem_enable = !reset && ((int'(count) + int'(inflight)) < FIFO_DEPTH);
    assign issue      = mem_enable && !mem_busy && !redirect;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= START_ADDRESS & 32'hFFFF_FFFC;
        end else if (redirect) begin
            pc <= redirect_pc & 32'hFFFF_FFFC;
        end else if (issue) begin
            pc <= pc + 32'd4;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) tags[i] <= '0;
        end else begin
            tags[0] <= {issue, pc};
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tags[i] <= {tags[i-1].valid && !redirect, tags[i-1].pc};
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (64),
        .CW    (CW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush   (redirect),
        .wr_en   (tags[MEM_LATENCY-1].valid && !redirect),
        .wr_data ({tags[MEM_LATENCY-1].pc, mem_data_out}),
        .rd_en   (insn_valid && insn_ready),
        .rd_data (head),
        .count   (count),
        .empty   (fifo_empty)
    );

    assign insn_valid = !fifo_empty;
    assign insn       = fifo_empty ? '0 : head[31:0];
    assign insn_pc    = fifo_empty ? '0 : head[63:32];

endmodule
